hilo_mdu: RTL and testbench
===========================

Name: hilo_mdu

Overview:
Parametrised HI/LO register pair with an integrated multi-cycle multiply/divide unit for the MIPS execute stage. It accepts MULT/MULTU/DIV/DIVU/MADD/MSUB from EX and direct MTHI/MTLO writes. Results are written into HI/LO on completion. It raises busy so the pipeline stalls, and it supports a flush (cancel) from exception logic.

Parameters:
WIDTH, 32, data width of operands and of each of HI and LO.
MUL_LAT, 3, multiply/MADD/MSUB latency in clock edges (must be >= 1).

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous reset, active-low (rst==0 resets; `RstEnable is 1'b0).
start  input  1  launch op; sampled only in IDLE.
op  input  3  operation code (package constants).
opa  input  WIDTH  operand A (dividend / multiplicand).
opb  input  WIDTH  operand B (divisor / multiplier).
cancel  input  1  flush the in-flight op.
whi  input  1  direct HI write enable (MTHI).
wlo  input  1  direct LO write enable (MTLO).
wHiData  input  WIDTH  MTHI data.
wLoData  input  WIDTH  MTLO data.
busy  output  1  op in flight; the pipeline must stall MDU/HI/LO consumers.
done  output  1  one-cycle pulse after the result lands in HI/LO.
rHiData  output  WIDTH  current HI.
rLoData  output  WIDTH  current LO.

Behaviour:
- Reset (rst==0 at an edge): HI=LO=0, state IDLE, busy=0, done=0. While rst==0, rHiData and rLoData are forced to 0 combinationally. Reset mid-operation aborts the op with no writeback.
- Reads: rHiData/rLoData come combinationally from the registers. There is no write-through bypass; a write becomes visible the cycle after its edge.
- States: IDLE, MUL, DIV, FIX.
- IDLE transitions:
  - start with a valid op and cancel==0 -> MUL or DIV, busy=1 from the next cycle.
  - Invalid op codes are ignored.
  - start while busy is ignored.
- MUL state:
  - Counter runs MUL_LAT edges from the start edge.
  - MULT/MULTU: {HI,LO} = full 2*WIDTH signed/unsigned product.
  - MADD/MSUB: {HI,LO} = {HI,LO} +/- signed product, using the HI/LO values at the writeback edge.
- DIV state:
  - Restoring division on operand magnitudes, one quotient bit per edge, WIDTH edges, then one edge in FIX for sign correction.
  - Total latency WIDTH+1 edges.
  - Quotient truncates toward zero into LO; remainder goes into HI and takes the sign of the dividend.
  - DIVU uses raw unsigned operands.
  - Overflow case MIN/-1: LO=MIN, HI=0.
- Divide by zero (opb==0, DIV or DIVU): latency 1 edge, HI=opa, LO=all ones.
- On the writeback edge: HI/LO are updated, state returns to IDLE, busy=0 and done=1 for exactly one cycle.
- Back-to-back: a new start is accepted in the cycle done is high.
- whi/wlo are honoured in any state. If one coincides with the op writeback edge, the op result wins for both registers.
- cancel: while busy, returns to IDLE at the next edge with no HI/LO write and no done. cancel together with start in IDLE drops the start.
- All arithmetic is modulo 2^(2*WIDTH); MADD/MSUB carries out of HI are discarded.

Decomposition:
- Shared define file holds:
  - op constants: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MADD=4, OP_MSUB=5.
  - `RstEnable/`RstDisable, `Valid, `Zero.
  - state encodings.
- One sub-module: hilo_div_iter, the iterative restoring divider with a start/done handshake and magnitude/sign handling. The multiply is inline: a registered product plus a MUL_LAT delay counter.

Test Plan (WIDTH=32, MUL_LAT=3):
1. Hold rst=0 for 2 cycles with whi=1 -> rHiData/rLoData=0. Release, then whi=1, wHiData=0x1234 -> rHiData=0x1234 next cycle, rLoData=0.
2. MULT opa=0xFFFFFFFE, opb=3 -> busy for 3 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done pulses once. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
3. DIV opa=-7 (0xFFFFFFF9), opb=2 -> after 33 edges LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU opa=7, opb=0 -> after 1 edge HI=7, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. Preload HI=0, LO=0xFFFFFFFF; MADD 1*1 -> HI=1, LO=0. Then MSUB 2*1 -> HI=0, LO=0xFFFFFFFE.
5. Start DIV and do the following in one run:
   - assert start with MULT mid-divide -> ignored;
   - assert whi on the writeback edge -> divider result in HI;
   - start another DIV and assert cancel at cycle 10 -> busy=0 next cycle, HI/LO unchanged, no done.
6. Start DIV, then drive rst=0 at cycle 5 -> HI=LO=0, busy=0, no done. After release, a new MULT 2*3 -> LO=6, HI=0.

Source files
------------

// File: rtl/hilo_mdu_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: reset and flag
// levels, operation codes, FSM state encoding and small op decoders.
package hilo_mdu_pkg;

   localparam logic RstEnable  = 1'b0;
   localparam logic RstDisable = 1'b1;
   localparam logic Valid      = 1'b1;
   localparam logic Zero       = 1'b0;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MADD  = 3'd4;
   localparam logic [2:0] OP_MSUB  = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } mduState_e;

   function automatic logic isValidOp(input logic [2:0] opCode);
      return (opCode <= OP_MSUB);
   endfunction

   function automatic logic isMulOp(input logic [2:0] opCode);
      return (opCode == OP_MULT) || (opCode == OP_MULTU) ||
             (opCode == OP_MADD) || (opCode == OP_MSUB);
   endfunction

endpackage

// File: rtl/hilo_div_iter.sv
// Iterative restoring divider: works on operand magnitudes, retires one
// quotient bit per clock edge and presents sign-corrected results once the
// last iteration has completed.
module hilo_div_iter
   import hilo_mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signedOp,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             lastStep,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CntW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] quoQ, quoD;
   logic [WIDTH-1:0] remQ, remD;
   logic [WIDTH-1:0] divQ, divD;
   logic [CntW-1:0]  cntQ, cntD;
   logic             negQuoQ, negQuoD;
   logic             negRemQ, negRemD;

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] trialDiff;
   logic             fits;
   logic             negA, negB;
   logic [WIDTH-1:0] magA, magB;

   // Operand magnitudes for signed division and the trial subtraction of
   // one restoring step. The partial remainder is always below the divisor,
   // so the low WIDTH bits of the difference are exact whenever it fits.
   always_comb begin
      negA      = signedOp & dividend[WIDTH-1];
      negB      = signedOp & divisor[WIDTH-1];
      magA      = negA ? -dividend : dividend;
      magB      = negB ? -divisor : divisor;
      shifted   = {remQ, quoQ[WIDTH-1]};
      fits      = (shifted >= {1'b0, divQ});
      trialDiff = shifted[WIDTH-1:0] - divQ;
   end

   // Next-state logic: a start reloads the operands and arms the iteration
   // counter; otherwise each edge with a nonzero count shifts in one more
   // quotient bit and restores the remainder when the subtraction fails.
   always_comb begin
      quoD    = quoQ;
      remD    = remQ;
      divD    = divQ;
      cntD    = cntQ;
      negQuoD = negQuoQ;
      negRemD = negRemQ;
      if (start) begin
         quoD    = magA;
         remD    = '0;
         divD    = magB;
         cntD    = CntW'(WIDTH);
         negQuoD = negA ^ negB;
         negRemD = negA;
      end else if (cntQ != '0) begin
         quoD = {quoQ[WIDTH-2:0], fits};
         remD = fits ? trialDiff : shifted[WIDTH-1:0];
         cntD = cntQ - CntW'(1);
      end
   end

   // Iteration registers, cleared by the synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         quoQ    <= '0;
         remQ    <= '0;
         divQ    <= '0;
         cntQ    <= '0;
         negQuoQ <= Zero;
         negRemQ <= Zero;
      end else begin
         quoQ    <= quoD;
         remQ    <= remD;
         divQ    <= divD;
         cntQ    <= cntD;
         negQuoQ <= negQuoD;
         negRemQ <= negRemD;
      end
   end

   // The quotient truncates toward zero and the remainder follows the sign
   // of the dividend; this also yields MIN/-1 = MIN with a zero remainder.
   always_comb begin
      lastStep  = (cntQ == CntW'(1));
      quotient  = negQuoQ ? -quoQ : quoQ;
      remainder = negRemQ ? -remQ : remQ;
   end

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO register pair with a multi-cycle multiply/divide unit for the
// execute stage. Multiplies use a registered product and a delay counter;
// divides use the iterative divider followed by a sign-fix cycle.
module hilo_mdu
   import hilo_mdu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             cancel,
   input  logic             whi,
   input  logic             wlo,
   input  logic [WIDTH-1:0] wHiData,
   input  logic [WIDTH-1:0] wLoData,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rHiData,
   output logic [WIDTH-1:0] rLoData
);

   localparam int MulCntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   mduState_e          stateQ, stateD;
   logic [WIDTH-1:0]   hiQ, hiD;
   logic [WIDTH-1:0]   loQ, loD;
   logic               doneQ, doneD;
   logic [2:0]         opQ, opD;
   logic [2*WIDTH-1:0] prodQ, prodD;
   logic [MulCntW-1:0] mulCntQ, mulCntD;
   logic               dzQ, dzD;
   logic [WIDTH-1:0]   dzHiQ, dzHiD;

   logic               signedMul;
   logic [2*WIDTH-1:0] aExt, bExt, product;
   logic [2*WIDTH-1:0] mulResult;
   logic               divStart;
   logic               divLast;
   logic [WIDTH-1:0]   divQuo, divRem;

   hilo_div_iter #(
      .WIDTH(WIDTH)
   ) uDiv (
      .clk      (clk),
      .rst      (rst),
      .start    (divStart),
      .signedOp (op == OP_DIV),
      .dividend (opa),
      .divisor  (opb),
      .lastStep (divLast),
      .quotient (divQuo),
      .remainder(divRem)
   );

   // One shared multiplier: operands are sign- or zero-extended to the full
   // product width so the truncated product is the correct signed/unsigned
   // result. MADD/MSUB accumulate against HI/LO as they are at writeback.
   always_comb begin
      signedMul = (op != OP_MULTU);
      aExt      = {{WIDTH{signedMul & opa[WIDTH-1]}}, opa};
      bExt      = {{WIDTH{signedMul & opb[WIDTH-1]}}, opb};
      product   = aExt * bExt;
      if (opQ == OP_MADD) begin
         mulResult = {hiQ, loQ} + prodQ;
      end else if (opQ == OP_MSUB) begin
         mulResult = {hiQ, loQ} - prodQ;
      end else begin
         mulResult = prodQ;
      end
   end

   // Control FSM and HI/LO next state. Direct MTHI/MTLO writes are applied
   // first so that an op writeback on the same edge overrides them; cancel
   // beats any writeback and drops back to IDLE silently.
   always_comb begin
      stateD   = stateQ;
      hiD      = hiQ;
      loD      = loQ;
      doneD    = Zero;
      opD      = opQ;
      prodD    = prodQ;
      mulCntD  = mulCntQ;
      dzD      = dzQ;
      dzHiD    = dzHiQ;
      divStart = Zero;
      if (whi) begin
         hiD = wHiData;
      end
      if (wlo) begin
         loD = wLoData;
      end
      case (stateQ)
         IDLE: begin
            if (start && isValidOp(op) && !cancel) begin
               opD = op;
               if (isMulOp(op)) begin
                  prodD   = product;
                  mulCntD = MulCntW'(MUL_LAT - 1);
                  stateD  = MUL;
               end else if (opb == '0) begin
                  dzD    = Valid;
                  dzHiD  = opa;
                  stateD = FIX;
               end else begin
                  dzD      = Zero;
                  divStart = Valid;
                  stateD   = DIV;
               end
            end
         end
         MUL: begin
            if (cancel) begin
               stateD = IDLE;
            end else if (mulCntQ == '0) begin
               {hiD, loD} = mulResult;
               doneD      = Valid;
               stateD     = IDLE;
            end else begin
               mulCntD = mulCntQ - MulCntW'(1);
            end
         end
         DIV: begin
            if (cancel) begin
               stateD = IDLE;
            end else if (divLast) begin
               stateD = FIX;
            end
         end
         FIX: begin
            if (cancel) begin
               stateD = IDLE;
            end else begin
               if (dzQ) begin
                  hiD = dzHiQ;
                  loD = '1;
               end else begin
                  hiD = divRem;
                  loD = divQuo;
               end
               doneD  = Valid;
               stateD = IDLE;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   // State and HI/LO registers; a reset aborts any op without writeback.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         stateQ  <= IDLE;
         hiQ     <= '0;
         loQ     <= '0;
         doneQ   <= Zero;
         opQ     <= OP_MULT;
         prodQ   <= '0;
         mulCntQ <= '0;
         dzQ     <= Zero;
         dzHiQ   <= '0;
      end else begin
         stateQ  <= stateD;
         hiQ     <= hiD;
         loQ     <= loD;
         doneQ   <= doneD;
         opQ     <= opD;
         prodQ   <= prodD;
         mulCntQ <= mulCntD;
         dzQ     <= dzD;
         dzHiQ   <= dzHiD;
      end
   end

   // Reads come straight from the registers, forced to zero while reset is
   // held so consumers never see stale values.
   always_comb begin
      busy    = (stateQ != IDLE);
      done    = doneQ;
      rHiData = (rst == RstEnable) ? '0 : hiQ;
      rLoData = (rst == RstEnable) ? '0 : loQ;
   end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed testbench for hilo_mdu with WIDTH=32 and MUL_LAT=3.
module tb_hilo_mdu;
   import hilo_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] opa, opb;
   logic        cancel;
   logic        whi, wlo;
   logic [31:0] wHiData, wLoData;
   logic        busy, done;
   logic [31:0] rHiData, rLoData;

   int assertCount = 0;
   int failCount   = 0;

   hilo_mdu #(
      .WIDTH  (32),
      .MUL_LAT(3)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .opa    (opa),
      .opb    (opb),
      .cancel (cancel),
      .whi    (whi),
      .wlo    (wlo),
      .wHiData(wHiData),
      .wLoData(wLoData),
      .busy   (busy),
      .done   (done),
      .rHiData(rHiData),
      .rLoData(rLoData)
   );

   // Free-running clock; stimulus and sampling happen on the falling edge.
   always #5 clk = ~clk;

   // Launch one op: hold start for a single rising edge and return at the
   // falling edge that follows the start edge.
   task automatic applyStimulus(input logic [2:0] opCode, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = opCode;
      opa   = a;
      opb   = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Count busy cycles until the op retires, bounded so a stuck DUT shows
   // up as a wrong cycle count instead of a hang.
   task automatic waitDone(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 100) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; whi = 1'b1; wlo = 1'b1;
      wHiData = 32'hAAAA5555; wLoData = 32'h5555AAAA;
      repeat (2) @(negedge clk);
      assertCount++; if (rHiData !== 32'h0) begin failCount++; $display("[TB] FAIL rst_hi_forced: got %h expected %h", rHiData, 32'h0); end
      assertCount++; if (rLoData !== 32'h0) begin failCount++; $display("[TB] FAIL rst_lo_forced: got %h expected %h", rLoData, 32'h0); end
      assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
      assertCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL rst_done: got %b expected 0", done); end
      whi = 1'b0; wlo = 1'b0; rst = 1'b1;
      @(negedge clk);
      assertCount++; if (rHiData !== 32'h0) begin failCount++; $display("[TB] FAIL rst_hi_reg: got %h expected %h", rHiData, 32'h0); end
      whi = 1'b1; wHiData = 32'h00001234;
      @(negedge clk);
      whi = 1'b0;
      assertCount++; if (rHiData !== 32'h00001234) begin failCount++; $display("[TB] FAIL mthi_hi: got %h expected %h", rHiData, 32'h00001234); end
      assertCount++; if (rLoData !== 32'h0) begin failCount++; $display("[TB] FAIL mthi_lo: got %h expected %h", rLoData, 32'h0); end
   endtask

   task automatic test_mult();
      int cyc;
      applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'h3);
      waitDone(cyc);
      assertCount++; if (cyc !== 3) begin failCount++; $display("[TB] FAIL mult_latency: got %0d expected 3", cyc); end
      assertCount++; if (done !== 1'b1) begin failCount++; $display("[TB] FAIL mult_done: got %b expected 1", done); end
      assertCount++; if (rHiData !== 32'hFFFFFFFF) begin failCount++; $display("[TB] FAIL mult_hi: got %h expected %h", rHiData, 32'hFFFFFFFF); end
      assertCount++; if (rLoData !== 32'hFFFFFFFA) begin failCount++; $display("[TB] FAIL mult_lo: got %h expected %h", rLoData, 32'hFFFFFFFA); end
      @(negedge clk);
      assertCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL mult_done_pulse: got %b expected 0", done); end
      applyStimulus(OP_MULTU, 32'hFFFFFFFE, 32'h3);
      waitDone(cyc);
      assertCount++; if (cyc !== 3) begin failCount++; $display("[TB] FAIL multu_latency: got %0d expected 3", cyc); end
      assertCount++; if (rHiData !== 32'h00000002) begin failCount++; $display("[TB] FAIL multu_hi: got %h expected %h", rHiData, 32'h00000002); end
      assertCount++; if (rLoData !== 32'hFFFFFFFA) begin failCount++; $display("[TB] FAIL multu_lo: got %h expected %h", rLoData, 32'hFFFFFFFA); end
   endtask

   task automatic test_div();
      logic [2:0]  tOp  [5] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIVU, OP_DIV};
      logic [31:0] tA   [5] = '{32'hFFFFFFF9, 32'h7, 32'h80000000, 32'hFFFFFFF9, 32'h7};
      logic [31:0] tB   [5] = '{32'h2, 32'h0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE};
      logic [31:0] tLo  [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFC, 32'hFFFFFFFD};
      logic [31:0] tHi  [5] = '{32'hFFFFFFFF, 32'h7, 32'h0, 32'h1, 32'h1};
      int          tLat [5] = '{33, 1, 33, 33, 33};
      int cyc;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(tOp[i], tA[i], tB[i]);
         waitDone(cyc);
         assertCount++; if (cyc !== tLat[i]) begin failCount++; $display("[TB] FAIL div%0d_latency: got %0d expected %0d", i, cyc, tLat[i]); end
         assertCount++; if (done !== 1'b1) begin failCount++; $display("[TB] FAIL div%0d_done: got %b expected 1", i, done); end
         assertCount++; if (rLoData !== tLo[i]) begin failCount++; $display("[TB] FAIL div%0d_lo: got %h expected %h", i, rLoData, tLo[i]); end
         assertCount++; if (rHiData !== tHi[i]) begin failCount++; $display("[TB] FAIL div%0d_hi: got %h expected %h", i, rHiData, tHi[i]); end
      end
   endtask

   task automatic test_madd();
      int cyc;
      whi = 1'b1; wHiData = 32'h0; wlo = 1'b1; wLoData = 32'hFFFFFFFF;
      @(negedge clk);
      whi = 1'b0; wlo = 1'b0;
      applyStimulus(OP_MADD, 32'h1, 32'h1);
      waitDone(cyc);
      assertCount++; if (cyc !== 3) begin failCount++; $display("[TB] FAIL madd_latency: got %0d expected 3", cyc); end
      assertCount++; if (rHiData !== 32'h1) begin failCount++; $display("[TB] FAIL madd_hi: got %h expected %h", rHiData, 32'h1); end
      assertCount++; if (rLoData !== 32'h0) begin failCount++; $display("[TB] FAIL madd_lo: got %h expected %h", rLoData, 32'h0); end
      applyStimulus(OP_MSUB, 32'h2, 32'h1);
      waitDone(cyc);
      assertCount++; if (rHiData !== 32'h0) begin failCount++; $display("[TB] FAIL msub_hi: got %h expected %h", rHiData, 32'h0); end
      assertCount++; if (rLoData !== 32'hFFFFFFFE) begin failCount++; $display("[TB] FAIL msub_lo: got %h expected %h", rLoData, 32'hFFFFFFFE); end
      applyStimulus(OP_MADD, 32'hFFFFFFFF, 32'h1);
      waitDone(cyc);
      assertCount++; if (rHiData !== 32'h0) begin failCount++; $display("[TB] FAIL madd_neg_hi: got %h expected %h", rHiData, 32'h0); end
      assertCount++; if (rLoData !== 32'hFFFFFFFD) begin failCount++; $display("[TB] FAIL madd_neg_lo: got %h expected %h", rLoData, 32'hFFFFFFFD); end
   endtask

   task automatic test_hazards();
      applyStimulus(OP_DIV, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      start = 1'b1; op = OP_MULT; opa = 32'd2; opb = 32'd3;
      @(negedge clk);
      start = 1'b0;
      assertCount++; if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL ignore_start_busy: got %b expected 1", busy); end
      repeat (26) @(negedge clk);
      assertCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL div_early_done: got %b expected 0", done); end
      whi = 1'b1; wHiData = 32'hDEADBEEF;
      @(negedge clk);
      whi = 1'b0;
      assertCount++; if (done !== 1'b1) begin failCount++; $display("[TB] FAIL wb_done: got %b expected 1", done); end
      assertCount++; if (rHiData !== 32'd2) begin failCount++; $display("[TB] FAIL wb_whi_hi: got %h expected %h", rHiData, 32'd2); end
      assertCount++; if (rLoData !== 32'd14) begin failCount++; $display("[TB] FAIL wb_whi_lo: got %h expected %h", rLoData, 32'd14); end
   endtask

   task automatic test_cancel();
      int doneSeen;
      applyStimulus(OP_DIV, 32'd50, 32'd3);
      repeat (3) @(negedge clk);
      wlo = 1'b1; wLoData = 32'h77;
      @(negedge clk);
      wlo = 1'b0;
      assertCount++; if (rLoData !== 32'h77) begin failCount++; $display("[TB] FAIL mtlo_busy_lo: got %h expected %h", rLoData, 32'h77); end
      repeat (6) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL cancel_busy: got %b expected 0", busy); end
      doneSeen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) doneSeen++;
         @(negedge clk);
      end
      assertCount++; if (doneSeen !== 0) begin failCount++; $display("[TB] FAIL cancel_no_done: got %0d pulses expected 0", doneSeen); end
      assertCount++; if (rHiData !== 32'd2) begin failCount++; $display("[TB] FAIL cancel_hi: got %h expected %h", rHiData, 32'd2); end
      assertCount++; if (rLoData !== 32'h77) begin failCount++; $display("[TB] FAIL cancel_lo: got %h expected %h", rLoData, 32'h77); end
      start = 1'b1; op = OP_MULT; opa = 32'd2; opb = 32'd3; cancel = 1'b1;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL cancel_start_busy: got %b expected 0", busy); end
      repeat (4) @(negedge clk);
      assertCount++; if (rLoData !== 32'h77) begin failCount++; $display("[TB] FAIL cancel_start_lo: got %h expected %h", rLoData, 32'h77); end
      start = 1'b1; op = 3'd7;
      @(negedge clk);
      start = 1'b0;
      assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL invalid_op_busy: got %b expected 0", busy); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      int doneSeen;
      applyStimulus(OP_DIV, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      assertCount++; if (rHiData !== 32'h0) begin failCount++; $display("[TB] FAIL midrst_hi_forced: got %h expected %h", rHiData, 32'h0); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
      assertCount++; if (rHiData !== 32'h0) begin failCount++; $display("[TB] FAIL midrst_hi: got %h expected %h", rHiData, 32'h0); end
      assertCount++; if (rLoData !== 32'h0) begin failCount++; $display("[TB] FAIL midrst_lo: got %h expected %h", rLoData, 32'h0); end
      doneSeen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) doneSeen++;
         @(negedge clk);
      end
      assertCount++; if (doneSeen !== 0) begin failCount++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", doneSeen); end
      applyStimulus(OP_MULT, 32'd2, 32'd3);
      waitDone(cyc);
      assertCount++; if (cyc !== 3) begin failCount++; $display("[TB] FAIL midrst_mult_latency: got %0d expected 3", cyc); end
      assertCount++; if (rLoData !== 32'd6) begin failCount++; $display("[TB] FAIL midrst_mult_lo: got %h expected %h", rLoData, 32'd6); end
      assertCount++; if (rHiData !== 32'h0) begin failCount++; $display("[TB] FAIL midrst_mult_hi: got %h expected %h", rHiData, 32'h0); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      applyStimulus(OP_MULTU, 32'h00010000, 32'h00010000);
      waitDone(cyc);
      assertCount++; if (done !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_first_done: got %b expected 1", done); end
      assertCount++; if (rHiData !== 32'h1) begin failCount++; $display("[TB] FAIL b2b_first_hi: got %h expected %h", rHiData, 32'h1); end
      assertCount++; if (rLoData !== 32'h0) begin failCount++; $display("[TB] FAIL b2b_first_lo: got %h expected %h", rLoData, 32'h0); end
      applyStimulus(OP_DIVU, 32'd100, 32'd7);
      assertCount++; if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_accept: got %b expected 1", busy); end
      waitDone(cyc);
      assertCount++; if (cyc !== 33) begin failCount++; $display("[TB] FAIL b2b_latency: got %0d expected 33", cyc); end
      assertCount++; if (rHiData !== 32'd2) begin failCount++; $display("[TB] FAIL b2b_hi: got %h expected %h", rHiData, 32'd2); end
      assertCount++; if (rLoData !== 32'd14) begin failCount++; $display("[TB] FAIL b2b_lo: got %h expected %h", rLoData, 32'd14); end
   endtask

   // Run every scenario in order, then print the summary.
   initial begin
      rst = 1'b0; start = 1'b0; op = OP_MULT; opa = '0; opb = '0; cancel = 1'b0;
      whi = 1'b0; wlo = 1'b0; wHiData = '0; wLoData = '0;
      @(negedge clk);
      $display("[TB] starting hilo_mdu directed tests");
      test_reset();
      test_mult();
      test_div();
      test_madd();
      test_hazards();
      test_cancel();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
